conv_bcd: RTL and testbench

Sequential signed-binary to BCD converter for the calculator datapath. It sits directly downstream of the adder/subtractor stage. It takes the 28-bit two's-complement result, its valid strobe and its overflow flag, and produces eight packed BCD digits plus sign and error flags for the display driver. The conversion uses a multi-cycle shift-and-add-3 (double-dabble) engine with a valid/busy handshake.

---
 rtl/conv_bcd.sv | 94 +++++++++
 tb/tb_conv_bcd.sv | 136 +++++++++++++
 2 files changed

// File: rtl/conv_bcd.sv
// rtl/conv_bcd.sv - sequential signed-binary to packed BCD converter (double-dabble)
module conv_bcd #(
  parameter int DIGITS = 8,
  parameter int W      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          d_in,
  input  logic                  valid_in,
  input  logic                  ovrflow_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  err,
  output logic                  valid_out,
  output logic                  busy
);

  localparam int SW = 4*DIGITS + W;
  localparam int CW = $clog2(W);
  localparam logic [63:0] LIMIT = 64'(10**DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic            valid_in_q;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   adj;
  logic [W-1:0]    mag_c;
  logic            neg_r;
  logic            err_r;
  logic            start;

  always_comb begin
    mag_c = d_in[W-1] ? (~d_in + W'(1)) : d_in;
    start = (state == IDLE) && valid_in && !valid_in_q;
  end

  always_comb begin
    adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[W+4*i +: 4] >= 4'd5)
        adj[W+4*i +: 4] = sr[W+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid_in_q <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      neg_r      <= 1'b0;
      err_r      <= 1'b0;
      bcd        <= '0;
      neg        <= 1'b0;
      err        <= 1'b0;
      valid_out  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid_in_q <= valid_in;
      valid_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_r <= d_in[W-1] & ~(d_in == '0);
            err_r <= ovrflow_in | ({{(64-W){1'b0}}, mag_c} > LIMIT);
            // The first shift is free: scratch is empty, so no nibble needs +3.
            sr    <= {{(4*DIGITS-1){1'b0}}, mag_c, 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= {adj[SW-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-2))
            state <= DONE;
        end
        DONE: begin
          bcd       <= err_r ? '0 : sr[SW-1:W];
          neg       <= err_r ? 1'b0 : neg_r;
          err       <= err_r;
          valid_out <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bcd.sv
// tb/tb_conv_bcd.sv - scoreboard bench for conv_bcd with directed vectors
module tb_conv_bcd;

  typedef struct {
    logic [31:0] bcd;
    logic        neg;
    logic        err;
    int          start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] d_in;
  logic        valid_in;
  logic        ovrflow_in;
  logic [31:0] bcd;
  logic        neg;
  logic        err;
  logic        valid_out;
  logic        busy;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  conv_bcd #(.DIGITS(8), .W(28)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .valid_in(valid_in), .ovrflow_in(ovrflow_in),
    .bcd(bcd), .neg(neg), .err(err), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every valid_out pops one expectation, including the latency.
  always @(negedge clk) begin
    if (rst === 1'b1 && valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bcd", bcd, e.bcd);
        check("neg", {31'd0, neg}, {31'd0, e.neg});
        check("err", {31'd0, err}, {31'd0, e.err});
        check("latency", 32'(cyc - e.start), 32'd28);
      end
    end
  end

  task automatic run(input logic [27:0] d, input logic o, input int hold,
                     input logic [31:0] eb, input logic en, input logic ee);
    exp_t e;
    int   s;
    @(negedge clk);
    d_in = d; ovrflow_in = o; valid_in = 1'b1;
    s = cyc + 1;
    e.bcd = eb; e.neg = en; e.err = ee; e.start = s;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    valid_in = 1'b0;
    while (cyc < s + 30) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b0; d_in = '0; valid_in = 1'b0; ovrflow_in = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_bcd", bcd, 32'd0);
    check("reset_busy_flags", {28'd0, neg, err, valid_out, busy}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_outputs", {bcd[27:0], neg, err, valid_out, busy}, 32'd0);

    run(28'd3946, 1'b0, 3, 32'h00003946, 1'b0, 1'b0);
    run(28'(-2436), 1'b0, 1, 32'h00002436, 1'b1, 1'b0);
    run(28'd0, 1'b0, 1, 32'h00000000, 1'b0, 1'b0);
    run(28'd99999999, 1'b0, 1, 32'h99999999, 1'b0, 1'b0);
    run(28'd100000020, 1'b0, 1, 32'h00000000, 1'b0, 1'b1);
    run(28'(-99999999), 1'b0, 1, 32'h99999999, 1'b1, 1'b0);
    run(28'h8000000, 1'b0, 1, 32'h00000000, 1'b0, 1'b1);
    run(28'd5, 1'b1, 1, 32'h00000000, 1'b0, 1'b1);

    // Second rising edge while busy must be dropped.
    @(negedge clk);
    d_in = 28'd1234; ovrflow_in = 1'b0; valid_in = 1'b1;
    s = cyc + 1;
    exp_q.push_back('{bcd: 32'h00001234, neg: 1'b0, err: 1'b0, start: s});
    @(negedge clk);
    valid_in = 1'b0;
    while (cyc < s + 9) @(negedge clk);
    d_in = 28'd777; valid_in = 1'b1;
    while (cyc < s + 27) @(negedge clk);
    check("busy_at_27", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("busy_at_28", {31'd0, busy}, 32'd0);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    run(28'd4321, 1'b0, 2, 32'h00004321, 1'b0, 1'b0);

    // Abort a conversion with reset at edge 15.
    @(negedge clk);
    d_in = 28'd12345678; valid_in = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    valid_in = 1'b0;
    while (cyc < s + 15) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_bcd", bcd, 32'd0);
    check("abort_flags", {28'd0, neg, err, valid_out, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    run(28'd87654321, 1'b0, 1, 32'h87654321, 1'b0, 1'b0);

    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
